// File: rtl/r4mdc_commutator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : r4mdc_commutator                                              |
// | Purpose  : Radix-4 MDC data commutator. Transposes 4x4 blocks of L       |
// |            samples across four complex lanes. Input lane j delivers      |
// |            B(j,0..3); output lane k delivers B(0,k), B(1,k), B(2,k),     |
// |            B(3,k). Built as input skew, rotating switch, output deskew.  |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            in_valid        - all four input lanes carry a sample         |
// |            flush           - advance with zero samples (in_valid=0)      |
// |            inN_r / inN_i   - lane N input, real / imag, WL bits          |
// |            outN_r / outN_i - lane N output, real / imag, registered      |
// |            out_valid       - outputs hold a valid transposed sample      |
// |            out_first       - first sample of an output frame             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module r4mdc_commutator #(
  parameter int WL = 16,
  parameter int L  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          flush,
  input  logic [WL-1:0] in0_r,
  input  logic [WL-1:0] in0_i,
  input  logic [WL-1:0] in1_r,
  input  logic [WL-1:0] in1_i,
  input  logic [WL-1:0] in2_r,
  input  logic [WL-1:0] in2_i,
  input  logic [WL-1:0] in3_r,
  input  logic [WL-1:0] in3_i,
  output logic [WL-1:0] out0_r,
  output logic [WL-1:0] out0_i,
  output logic [WL-1:0] out1_r,
  output logic [WL-1:0] out1_i,
  output logic [WL-1:0] out2_r,
  output logic [WL-1:0] out2_i,
  output logic [WL-1:0] out3_r,
  output logic [WL-1:0] out3_i,
  output logic          out_valid,
  output logic          out_first
);

  localparam int c_frame = 4 * L;
  localparam int c_cnt_w = $clog2(c_frame);
  localparam int c_dw    = 2 * WL;
  localparam int c_tag_d = 3 * L;

  logic               w_adv;
  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;
  logic [1:0]         w_sel;
  logic [c_dw-1:0]    w_in   [4];
  logic [c_dw-1:0]    w_skew [4];
  logic [c_dw-1:0]    w_sw   [4];
  logic [c_dw-1:0]    w_desk [4];
  logic [c_dw-1:0]    out_q  [4];
  logic               out_valid_q;
  logic               out_first_q;
  // Tag bit 1 = sample valid, bit 0 = first sample of the input frame.
  logic [1:0]         tag_q  [c_tag_d];
  logic [1:0]         w_tag_in;

  assign w_adv = in_valid | flush;

  // Flush-only cycles push zeros into the delay lines.
  always_comb begin
    w_in[0] = in_valid ? {in0_r, in0_i} : '0;
    w_in[1] = in_valid ? {in1_r, in1_i} : '0;
    w_in[2] = in_valid ? {in2_r, in2_i} : '0;
    w_in[3] = in_valid ? {in3_r, in3_i} : '0;
  end

  // Segment counter; 4L is a power of two so the natural wrap is the frame wrap.
  assign cnt_d = cnt_q + c_cnt_w'(1);
  assign w_sel = cnt_q[c_cnt_w-1 -: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (w_adv) begin
      cnt_q <= cnt_d;
    end
  end

  // Input skew: lane j delayed by j*L advance cycles.
  for (genvar j = 0; j < 4; j++) begin : g_skew
    if (j == 0) begin : g_pass
      assign w_skew[j] = w_in[j];
    end else begin : g_dly
      logic [c_dw-1:0] sr_q [j*L];
      always_ff @(posedge clk) begin
        if (w_adv) begin
          sr_q[0] <= w_in[j];
          for (int i = 1; i < j * L; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
        end
      end
      assign w_skew[j] = sr_q[j*L-1];
    end
  end

  // Rotating switch: during segment sel, lane k picks skewed lane (sel-k) mod 4.
  // The 2-bit subtraction provides the mod 4.
  for (genvar k = 0; k < 4; k++) begin : g_switch
    assign w_sw[k] = w_skew[w_sel - 2'(k)];
  end

  // Output deskew: lane k delayed by (3-k)*L so every path totals 3L.
  for (genvar k = 0; k < 4; k++) begin : g_deskew
    if (k == 3) begin : g_pass
      assign w_desk[k] = w_sw[k];
    end else begin : g_dly
      logic [c_dw-1:0] sr_q [(3-k)*L];
      always_ff @(posedge clk) begin
        if (w_adv) begin
          sr_q[0] <= w_sw[k];
          for (int i = 1; i < (3 - k) * L; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
        end
      end
      assign w_desk[k] = sr_q[(3-k)*L-1];
    end
  end

  // Valid/first tags follow the same 3L advance-cycle latency as the data.
  assign w_tag_in = {in_valid, in_valid & (cnt_q == '0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_tag_d; i++) begin
        tag_q[i] <= '0;
      end
    end else if (w_adv) begin
      tag_q[0] <= w_tag_in;
      for (int i = 1; i < c_tag_d; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Output register: data holds through stalls, flags only pulse on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= w_desk[k];
      end
      out_valid_q <= tag_q[c_tag_d-1][1];
      out_first_q <= tag_q[c_tag_d-1][0];
    end else begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
    end
  end

  assign out0_r    = out_q[0][c_dw-1:WL];
  assign out0_i    = out_q[0][WL-1:0];
  assign out1_r    = out_q[1][c_dw-1:WL];
  assign out1_i    = out_q[1][WL-1:0];
  assign out2_r    = out_q[2][c_dw-1:WL];
  assign out2_i    = out_q[2][WL-1:0];
  assign out3_r    = out_q[3][c_dw-1:WL];
  assign out3_i    = out_q[3][WL-1:0];
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;

endmodule
`default_nettype wire

// File: tb/tb_r4mdc_commutator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_r4mdc_commutator                                           |
// | Purpose  : Self-checking bench for r4mdc_commutator. Three instances     |
// |            (L=2, L=1, L=4) share one clock; one is active per scenario.  |
// |            Expected transposed frames are queued as input is driven and  |
// |            compared against output records as they appear.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_r4mdc_commutator;

  typedef struct packed {
    logic            first;
    logic [3:0][15:0] r;
    logic [3:0][15:0] im;
  } rec_t;

  typedef struct {
    int inst;
    int frames;
    int stall_at;
    int stall_len;
    bit rnd;
    int exp_lat;
    int exp_span;
    int exp_cnt;
  } scen_t;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] in_r  [3][4];
  logic [15:0] in_i  [3][4];
  logic [15:0] out_r [3][4];
  logic [15:0] out_i [3][4];
  logic        inv   [3];
  logic        fl    [3];
  logic        rst_v [3];
  logic        ov    [3];
  logic        of    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LG = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    r4mdc_commutator #(.WL(16), .L(LG)) u_dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .in_valid (inv[g]),
      .flush    (fl[g]),
      .in0_r    (in_r[g][0]),
      .in0_i    (in_i[g][0]),
      .in1_r    (in_r[g][1]),
      .in1_i    (in_i[g][1]),
      .in2_r    (in_r[g][2]),
      .in2_i    (in_i[g][2]),
      .in3_r    (in_r[g][3]),
      .in3_i    (in_i[g][3]),
      .out0_r   (out_r[g][0]),
      .out0_i   (out_i[g][0]),
      .out1_r   (out_r[g][1]),
      .out1_i   (out_i[g][1]),
      .out2_r   (out_r[g][2]),
      .out2_i   (out_i[g][2]),
      .out3_r   (out_r[g][3]),
      .out3_i   (out_i[g][3]),
      .out_valid(ov[g]),
      .out_first(of[g])
    );
  end

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   cur   = 0;
  int   lc    = 2;
  int   stride = 16;
  bit   det   = 1'b0;
  bit   armed = 1'b0;
  int   fpos  = 0;
  int   ocnt  = 0;
  int   first_in  = -1;
  int   first_out = -1;
  int   last_out  = -1;
  rec_t exp_q [$];
  rec_t act_q [$];
  logic [15:0] fr [4][16];
  logic [15:0] fi [4][16];
  bit   advp [3];
  bit   rstp [3];
  logic [3:0][15:0] snap_r [3];
  logic [3:0][15:0] snap_i [3];
  logic [3:0][15:0] mon_r, mon_i, cf_r, cf_i;
  rec_t mon_a, mon_e;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      advp[i] = inv[i] | fl[i];
      rstp[i] = rst_v[i];
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        mon_r[k] = out_r[i][k];
        mon_i[k] = out_i[i][k];
      end
      if (armed) begin
        if (rstp[i]) begin
          chk("reset_state", {ov[i], of[i], mon_r, mon_i}, '0);
        end else if (!advp[i]) begin
          chk("stall_flags", {158'd0, ov[i], of[i]}, '0);
          chk("stall_hold", {mon_r, mon_i}, {snap_r[i], snap_i[i]});
        end
      end
      snap_r[i] = mon_r;
      snap_i[i] = mon_i;
      if (armed && i == cur && !rstp[i] && ov[i] === 1'b1) begin
        mon_a.first = of[i];
        mon_a.r     = mon_r;
        mon_a.im    = mon_i;
        act_q.push_back(mon_a);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (det) begin
          for (int k = 0; k < 4; k++) begin
            cf_r[k] = 16'(stride * ((ocnt % (4 * lc)) / lc) + k * lc
                          + (ocnt % lc) + 256 * (ocnt / (4 * lc)));
            cf_i[k] = cf_r[k] + 16'd128;
          end
          chk("closed_form", {mon_r, mon_i}, {cf_r, cf_i});
        end
        ocnt++;
      end
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = act_q.pop_front();
      chk("scoreboard", 160'(mon_a), 160'(mon_e));
    end
  end

  // One clock of stimulus on the current instance; queues the expected
  // transposed frame once all 4L input samples of it are known.
  task automatic step(input bit v, input bit f, input bit r,
                      input logic [3:0][15:0] dr, input logic [3:0][15:0] di);
    rec_t e;
    rst_v[cur] = r;
    inv[cur]   = v;
    fl[cur]    = f;
    for (int j = 0; j < 4; j++) begin
      in_r[cur][j] = dr[j];
      in_i[cur][j] = di[j];
    end
    if (v && !r) begin
      for (int j = 0; j < 4; j++) begin
        fr[j][fpos] = dr[j];
        fi[j][fpos] = di[j];
      end
      fpos++;
      if (fpos == 4 * lc) begin
        for (int c = 0; c < 4 * lc; c++) begin
          e.first = (c == 0);
          for (int k = 0; k < 4; k++) begin
            e.r[k]  = fr[c / lc][k * lc + (c % lc)];
            e.im[k] = fi[c / lc][k * lc + (c % lc)];
          end
          exp_q.push_back(e);
        end
        fpos = 0;
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      act_q.delete();
      fpos = 0;
      ocnt = 0;
      first_in  = -1;
      first_out = -1;
      last_out  = -1;
    end else if (v && first_in < 0) begin
      first_in = cyc;
    end
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) step(1'b0, f, 1'b0, '0, '0);
  endtask

  task automatic frame_sample(input int f, input int c);
    logic [3:0][15:0] dr, di;
    for (int j = 0; j < 4; j++) begin
      if (det) begin
        dr[j] = 16'(stride * j + c + 256 * f);
        di[j] = dr[j] + 16'd128;
      end else begin
        dr[j] = 16'($urandom);
        di[j] = 16'($urandom);
      end
    end
    step(1'b1, 1'b0, 1'b0, dr, di);
  endtask

  task automatic select(input int inst, input bit d);
    cur    = inst;
    lc     = (inst == 0) ? 2 : ((inst == 1) ? 1 : 4);
    stride = (lc == 1) ? 4 : 16;
    det    = d;
    step(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic final_checks(input int exp_cnt, input int lat, input int span);
    chk("valid_count", 160'(ocnt), 160'(exp_cnt));
    chk("drained", 160'(exp_q.size() + act_q.size()), '0);
    if (lat >= 0) chk("latency", 160'(first_out - first_in), 160'(lat));
    if (span >= 0) chk("contiguous", 160'(last_out - first_out), 160'(span));
  endtask

  scen_t tab [5];

  initial begin
    tab[0] = '{inst: 0, frames: 1,  stall_at: -1, stall_len: 0, rnd: 0, exp_lat: 6,  exp_span: 7,  exp_cnt: 8};
    tab[1] = '{inst: 0, frames: 3,  stall_at: -1, stall_len: 0, rnd: 0, exp_lat: 6,  exp_span: 23, exp_cnt: 24};
    tab[2] = '{inst: 0, frames: 1,  stall_at: 3,  stall_len: 3, rnd: 0, exp_lat: 9,  exp_span: 7,  exp_cnt: 8};
    tab[3] = '{inst: 1, frames: 1,  stall_at: -1, stall_len: 0, rnd: 0, exp_lat: 3,  exp_span: 3,  exp_cnt: 4};
    tab[4] = '{inst: 2, frames: 10, stall_at: -1, stall_len: 0, rnd: 1, exp_lat: -1, exp_span: -1, exp_cnt: 160};

    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1;
      inv[i]   = 1'b0;
      fl[i]    = 1'b0;
      for (int j = 0; j < 4; j++) begin
        in_r[i][j] = '0;
        in_i[i][j] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

    for (int s = 0; s < 5; s++) begin
      select(tab[s].inst, !tab[s].rnd);
      for (int f = 0; f < tab[s].frames; f++) begin
        for (int c = 0; c < 4 * lc; c++) begin
          if (f * 4 * lc + c == tab[s].stall_at) idle(tab[s].stall_len, 1'b0);
          if (tab[s].rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b0);
          frame_sample(f, c);
        end
      end
      idle(3 * lc, 1'b1);
      idle(4, 1'b0);
      final_checks(tab[s].exp_cnt, tab[s].exp_lat, tab[s].exp_span);
    end

    // Reset at frame cycle 5 aborts the frame; a fresh frame must map cleanly.
    select(0, 1'b1);
    for (int c = 0; c < 5; c++) frame_sample(0, c);
    step(1'b1, 1'b0, 1'b1, '0, '0);
    for (int c = 0; c < 8; c++) frame_sample(0, c);
    idle(6, 1'b1);
    idle(4, 1'b0);
    final_checks(8, 6, 7);

    // in_valid=1 with flush=1 must behave as a plain valid sample.
    select(1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      logic [3:0][15:0] dr, di;
      for (int j = 0; j < 4; j++) begin
        dr[j] = 16'(4 * j + c);
        di[j] = dr[j] + 16'd128;
      end
      step(1'b1, 1'b1, 1'b0, dr, di);
    end
    idle(3, 1'b1);
    idle(3, 1'b0);
    final_checks(4, 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/r4mdc_commutator.md
Name: r4mdc_commutator

Overview:
- Parametrised radix-4 MDC data commutator: a 4-lane, 4x4 block transposer with a segment length of L samples.
- Per 4L-sample frame, input lane j carries blocks B(j,0..3) in order; output lane k carries B(0,k), B(1,k), B(2,k), B(3,k).
- Sits between butterfly stages of the radix-4 MDC FFT, and at the FFT output.
- Supersedes the fixed 4-sample output skewer. Adds configurable segment length, valid gating, flush and frame marking.

Parameters:
WL, 16, bit width of each real/imag component.
L, 4, segment length in samples. Power of two, >= 1. Frame = 4L valid samples.

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  reset, synchronous and active-high
in_valid  in  1  all four input lanes carry a sample this cycle
flush  in  1  advance the pipeline with zero samples while in_valid=0
in0_r..in3_r  in  WL each  lane 0..3 real part
in0_i..in3_i  in  WL each  lane 0..3 imag part
out0_r..out3_r  out  WL each  lane 0..3 real part, registered
out0_i..out3_i  out  WL each  lane 0..3 imag part, registered
out_valid  out  1  outputs hold a valid transposed sample
out_first  out  1  first sample (block 0, index 0) of an output frame; only with out_valid

Behaviour:
- Reset: synchronous, active-high. Takes effect at the rising edge where rst=1 and overrides in_valid/flush.
  - Clears the segment counter, all valid tags, out*, out_valid and out_first to 0.
  - Delay-line data need not be cleared; its tags are 0.
- Reset mid-frame discards all in-flight samples. The next accepted sample is frame cycle 0.
- Advance condition: adv = in_valid OR flush. With in_valid=1, flush is ignored.
  - When adv=0, all state holds, out* hold, out_valid=0 and out_first=0.
- Segment counter cnt, log2(4L) bits: increments on every adv and wraps 4L-1 -> 0. Segment sel = cnt / L (top 2 bits).
- Input skew: lane j passes through a j*L-deep shift register (lane 0 zero depth). Shifts only on adv.
  - Under flush, zeros are written and the valid tag is 0.
- Switch: at segment sel, pre-delay output lane k takes skewed lane (sel - k) mod 4.
- Output deskew: lane k passes through a (3-k)*L-deep shift register, shifting on adv, then the output register.
- Valid tag: a 1-bit tag travels through a 3L-deep shift register on adv. It also carries a first-flag, set when cnt=0 at acceptance.
  - out_valid = tag at the output register on an adv cycle.
  - out_first = the first-flag of that tag.
- Latency: a sample accepted at edge n with continuous adv appears on out* after edge n+3L. Stalls stretch latency by the stall count.
- Mapping: output frame cycle c (block m = c/L, idx = c mod L) on lane k = input lane m, frame cycle k*L + idx.
- Draining: the last frame fully drains after 3L flush (or valid) cycles.
- Back-to-back frames produce no bubbles.
- L=1 is a legal degenerate case: plain 4x4 transpose, latency 3.
- Data are pass-through only: no arithmetic, no width change. Real and imag share the same routing.
- No in_ready: the block always accepts.

Test Plan:
- L=2, continuous in_valid for one frame, input lane j cycle c = 16j+c (imag = real+128), then 6 flush cycles.
  -> First out_valid after edge 6 with out_first=1. Out lane k cycle c = 16(c/2) + 2k + (c mod 2); 8 valid outputs, then out_valid=0.
- L=2, three back-to-back frames, then 6 flush cycles.
  -> 24 consecutive out_valid cycles. out_first at output cycles 0, 8, 16. Mapping correct per frame.
- L=2, in_valid deasserted 3 cycles mid-frame with flush=0.
  -> Outputs hold, out_valid=0 during the stall. Final sequence is identical to the no-stall case, shifted by 3 cycles.
- L=2, rst pulsed at frame cycle 5, then a fresh frame.
  -> No out_valid from the aborted frame. The new frame maps correctly, with out_first 6 edges after its first sample.
- L=1, one frame of input lane j cycle c = 4j+c, then 3 flush cycles.
  -> Out lane k cycle c = 4c+k; latency 3.
- L=4, random data, 10 frames with random in_valid gaps.
  -> Scoreboard matches the transpose mapping. out_valid count = 40 x 4 lane-samples.
